// File: rtl/io_pattern_sequencer_if.sv
// Command channel into the IO pattern sequencer: valid/ready handshake
// carrying the pattern mode and the loop count.
interface io_pattern_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_loops;

  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_loops,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_loops,
    output cmd_ready
  );
endinterface

// File: rtl/io_pattern_sequencer.sv
// Steps a selectable test pattern across the IO bank, one step per divider
// tick, for a fixed or unlimited number of passes. Drives the status LED.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | outputs parked at 0, waiting for a run command
//   RUN    | pattern follows pos; ticks advance pos / loop count
//   DONE   | one-cycle completion pulse, command channel held off
module io_pattern_sequencer #(
  parameter int NUM_PINS = 20,
  parameter int POS_W    = $clog2(NUM_PINS)
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  tick,
  io_pattern_sequencer_if.slave cmd,
  output logic [NUM_PINS-1:0]   io_out,
  output logic                  busy,
  output logic                  done,
  output logic                  nLED_RED,
  output logic                  nLED_GRN,
  output logic                  nLED_BLU
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]          MODE_WALK1  = 2'd0;
  localparam logic [1:0]          MODE_WALK0  = 2'd1;
  localparam logic [1:0]          MODE_TOGGLE = 2'd2;
  localparam logic [1:0]          MODE_STOP   = 2'd3;
  localparam logic [POS_W-1:0]    POS_LAST    = POS_W'(NUM_PINS - 1);
  localparam logic [NUM_PINS-1:0] ONE_HOT0    = NUM_PINS'(1);

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [3:0]          loops_q, loops_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [3:0]          loop_cnt_q, loop_cnt_d;
  logic                red_q, red_d;
  logic [NUM_PINS-1:0] io_out_q, io_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                led_red_q, led_red_d;
  logic                led_grn_q, led_grn_d;
  logic                led_blu_q, led_blu_d;

  logic cmd_acc;
  logic cmd_run;

  // Ready is withheld in DONE and while reset is asserted.
  assign cmd.cmd_ready = nRst && (state_q != S_DONE);
  assign cmd_acc       = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_run       = cmd_acc && (cmd.cmd_mode != MODE_STOP);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_WALK1;
      loops_q    <= '0;
      pos_q      <= '0;
      loop_cnt_q <= '0;
      red_q      <= 1'b0;
      io_out_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      led_red_q  <= 1'b1;
      led_grn_q  <= 1'b1;
      led_blu_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      loops_q    <= loops_d;
      pos_q      <= pos_d;
      loop_cnt_q <= loop_cnt_d;
      red_q      <= red_d;
      io_out_q   <= io_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      led_red_q  <= led_red_d;
      led_grn_q  <= led_grn_d;
      led_blu_q  <= led_blu_d;
    end
  end

  // Next state: an accepted command always beats a same-cycle tick.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    loops_d    = loops_q;
    pos_d      = pos_q;
    loop_cnt_d = loop_cnt_q;
    red_d      = red_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_run) begin
          state_d    = S_RUN;
          mode_d     = cmd.cmd_mode;
          loops_d    = cmd.cmd_loops;
          pos_d      = '0;
          loop_cnt_d = '0;
          red_d      = 1'b0;
        end
      end
      S_RUN: begin
        if (cmd_run) begin
          mode_d     = cmd.cmd_mode;
          loops_d    = cmd.cmd_loops;
          pos_d      = '0;
          loop_cnt_d = '0;
          red_d      = 1'b0;
        end else if (cmd_acc) begin
          state_d    = S_IDLE;
          pos_d      = '0;
          loop_cnt_d = '0;
        end else if (tick) begin
          if (pos_q == POS_LAST) begin
            pos_d      = '0;
            loop_cnt_d = loop_cnt_q + 4'd1;
            if ((loops_q != 4'd0) && (loop_cnt_q == loops_q - 4'd1)) begin
              state_d = S_DONE;
              red_d   = 1'b1;
            end
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state so io_out tracks pos with no lag.
  always_comb begin
    io_out_d  = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    led_red_d = 1'b1;
    led_grn_d = 1'b1;
    led_blu_d = 1'b1;
    case (state_d)
      S_RUN: begin
        busy_d    = 1'b1;
        led_grn_d = 1'b0;
        case (mode_d)
          MODE_WALK1:  io_out_d = ONE_HOT0 << pos_d;
          MODE_WALK0:  io_out_d = ~(ONE_HOT0 << pos_d);
          MODE_TOGGLE: io_out_d = pos_d[0] ? '0 : '1;
          default:     io_out_d = '0;
        endcase
      end
      S_DONE: begin
        done_d    = 1'b1;
        led_red_d = 1'b0;
      end
      default: begin
        if (red_d) led_red_d = 1'b0;
        else       led_blu_d = 1'b0;
      end
    endcase
  end

  assign io_out   = io_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign nLED_RED = led_red_q;
  assign nLED_GRN = led_grn_q;
  assign nLED_BLU = led_blu_q;

endmodule
